// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite transfer types, constants and the transfer-legality helper.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} sram_state_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Transfer fits the bus and is naturally aligned to its own size.
    function automatic logic size_legal(input logic [2:0] hsize, input logic [31:0] addr, input int dwidth);
        int bytes;
        bytes = 1 << hsize;
        return (bytes <= dwidth / 8) && ((addr & 32'(bytes - 1)) == 32'd0);
    endfunction
endpackage

// File: rtl/ahb_lane_decode.sv
// ahb_lane_decode: hsize + byte offset -> byte-enable mask and legality flag for any AHB slave.
module ahb_lane_decode
    import ahb_pkg::*;
#(
    parameter int DWIDTH = 32,
    localparam int NB = DWIDTH / 8,
    localparam int OW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [2:0]    i_hsize,
    input  logic [OW-1:0] i_off,
    output logic [NB-1:0] o_be,
    output logic          o_legal
);
    always_comb begin
        o_be = '0;
        for (int i = 0; i < NB; i++)
            o_be[i] = (i >= int'(i_off)) && (i < int'(i_off) + (1 << i_hsize));
    end

    assign o_legal = size_legal(i_hsize, 32'(i_off), DWIDTH);
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-lite on-chip SRAM slave with programmable wait states and byte-lane writes.
// Define AHB_SRAM_ERR_RESP_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic [31:0]       haddr,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [DWIDTH-1:0] hwdata,
    output logic [DWIDTH-1:0] hrdata,
    output logic              hready,
    output logic              hresp
);
    localparam int NB = DWIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int OW = (NB > 1) ? OB : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    sram_state_t       r_state;
    sram_state_t       w_next;
    sram_state_t       w_acc_state;
    logic [CW-1:0]     r_cnt;
    logic              r_hready;
    logic [IW-1:0]     r_word;
    logic [NB-1:0]     r_be;
    logic              r_write;
    logic              r_legal;
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [31:0]       w_word;
    logic [OW-1:0]     w_off;
    logic [NB-1:0]     w_be;
    logic              w_lane_ok;
    logic              w_legal;
    logic              w_accept;
    logic              w_wait_done;

    assign w_word = haddr >> OB;
    assign w_off  = OW'(haddr % NB);

    ahb_lane_decode #(.DWIDTH(DWIDTH)) u_lane (
        .i_hsize (hsize),
        .i_off   (w_off),
        .o_be    (w_be),
        .o_legal (w_lane_ok)
    );

    assign w_legal     = w_lane_ok && (w_word < 32'(DEPTH));
    assign w_accept    = hsel && (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ}) && r_hready;
    assign w_wait_done = int'(r_cnt) == WAIT_STATES - 1;

`ifdef AHB_SRAM_ERR_RESP_EN
    assign w_acc_state = !w_legal ? ST_ERR1 : (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`else
    assign w_acc_state = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`endif

    // IDLE, DATA and ERR2 all present hready=1, so each may take a new address phase.
    assign w_next = (r_state == ST_WAIT) ? (w_wait_done ? ST_DATA : ST_WAIT) :
                    (r_state == ST_ERR1) ? ST_ERR2 :
                    w_accept ? w_acc_state : ST_IDLE;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_cnt    <= '0;
            r_word   <= '0;
            r_be     <= '0;
            r_write  <= 1'b0;
            r_legal  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_hready <= !(w_next inside {ST_WAIT, ST_ERR1});
            r_cnt    <= (r_state == ST_WAIT && !w_wait_done) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_word  <= IW'(w_word);
                r_be    <= w_be;
                r_write <= hwrite;
                r_legal <= w_legal;
            end
        end
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    logic r_hresp;
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            r_hresp <= HRESP_OKAY;
        else
            r_hresp <= (w_next inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    end
    assign hresp = r_hresp;
`else
    assign hresp = HRESP_OKAY;
`endif

    // Writes commit at the end of DATA, so a following read's DATA cycle sees them.
    always_ff @(posedge hclk) begin
        if (r_state == ST_DATA && r_write && r_legal)
            for (int i = 0; i < NB; i++)
                if (r_be[i])
                    r_mem[r_word][8*i +: 8] <= hwdata[8*i +: 8];
    end

    assign hready = r_hready;
    assign hrdata = (r_state == ST_DATA && !r_write && r_legal) ? r_mem[r_word] : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: drives three slaves (0, 2 and 3 wait states) against a transfer-level memory model.
module tb_ahb_sram_slave;
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } tx_t;

`ifdef AHB_SRAM_ERR_RESP_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int WS [3] = '{0, 2, 3};

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel_v   [3];
    logic [1:0]  htrans_v [3];
    logic [31:0] haddr_v  [3];
    logic [2:0]  hsize_v  [3];
    logic        hwrite_v [3];
    logic [31:0] hwdata_v [3];
    logic [31:0] hrdata_v [3];
    logic        hready_v [3];
    logic        hresp_v  [3];

    logic [31:0] mm [3][256];
    tx_t         q [$];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_sram_slave #(.DWIDTH(32), .DEPTH(256), .WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
            .hclk   (hclk),
            .hreset (hreset),
            .hsel   (hsel_v[g]),
            .htrans (htrans_v[g]),
            .haddr  (haddr_v[g]),
            .hsize  (hsize_v[g]),
            .hwrite (hwrite_v[g]),
            .hwdata (hwdata_v[g]),
            .hrdata (hrdata_v[g]),
            .hready (hready_v[g]),
            .hresp  (hresp_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input tx_t t);
        int n;
        n = 1 << t.size;
        return n <= 4 && t.addr % n == 0 && t.addr / 4 < 256;
    endfunction

    task automatic add(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] wd);
        tx_t t;
        t.addr = a; t.size = s; t.wr = w; t.wdata = wd;
        q.push_back(t);
    endtask

    // Issue every queued transfer back to back on slave d; the model applies each
    // transfer when its data phase completes.
    task automatic run(input int d);
        bit  pend = 0;
        tx_t p;
        int  low = 0;
        int  i = 0;
        int  cyc = 0;
        bit  bad;
        while ((i < q.size() || pend) && cyc < 2000) begin
            if (i < q.size()) begin
                hsel_v[d] = 1'b1; htrans_v[d] = 2'b10; haddr_v[d] = q[i].addr;
                hsize_v[d] = q[i].size; hwrite_v[d] = q[i].wr;
            end else begin
                hsel_v[d] = 1'b0; htrans_v[d] = 2'b00;
            end
            hwdata_v[d] = pend ? p.wdata : 32'h0;
            @(negedge hclk);
            if (pend) begin
                bad = !legal(p);
                if (!hready_v[d]) begin
                    low++;
                    chk("wait_resp", hresp_v[d], ERR && bad);
                    chk("wait_rdata", hrdata_v[d], 32'h0);
                end else begin
                    chk("wait_len", low, (ERR && bad) ? 1 : WS[d]);
                    chk("done_resp", hresp_v[d], ERR && bad);
                    if (!p.wr) begin
                        chk("rdata", hrdata_v[d], bad ? 32'h0 : mm[d][int'(p.addr >> 2)]);
                        last_rd = hrdata_v[d];
                    end else if (!bad) begin
                        for (int b = 0; b < (1 << p.size); b++) begin
                            int l;
                            l = int'(p.addr % 4) + b;
                            mm[d][int'(p.addr >> 2)][8*l +: 8] = p.wdata[8*l +: 8];
                        end
                    end
                    pend = 0;
                end
            end else begin
                chk("idle_ready", hready_v[d], 1'b1);
            end
            if (hready_v[d] && i < q.size()) begin
                p = q[i]; i++; pend = 1; low = 0;
            end
            @(posedge hclk); #1;
            cyc++;
        end
        if (cyc >= 2000) chk("timeout", 1, 0);
        hsel_v[d] = 1'b0; htrans_v[d] = 2'b00;
        q.delete();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            hsel_v[d] = 0; htrans_v[d] = 0; haddr_v[d] = 0;
            hsize_v[d] = 0; hwrite_v[d] = 0; hwdata_v[d] = 0;
        end
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", hready_v[d], 1'b1);
            chk("reset_resp", hresp_v[d], 1'b0);
            chk("reset_rdata", hrdata_v[d], 32'h0);
        end
        hreset = 1'b0;
        @(posedge hclk); #1;

        // Give every slave known contents in words 0..15.
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) add(32'(w * 4), 3'd2, 1'b1, $urandom);
            run(d);
        end

        // Back-to-back write then read of the same word at zero wait states.
        add(32'h10, 3'd2, 1'b1, 32'hDEADBEEF);
        add(32'h10, 3'd2, 1'b0, 32'h0);
        run(0);
        chk("t2_rdata", last_rd, 32'hDEADBEEF);

        // Byte and halfword lanes.
        add(32'h10, 3'd2, 1'b1, 32'h11223344);
        add(32'h13, 3'd0, 1'b1, 32'hAA000000);
        add(32'h10, 3'd2, 1'b0, 32'h0);
        run(0);
        chk("t3_byte", last_rd, 32'hAA223344);
        add(32'h12, 3'd1, 1'b1, 32'h55660000);
        add(32'h10, 3'd2, 1'b0, 32'h0);
        run(0);
        chk("t3_half", last_rd, 32'h55663344);

        // Wait-state reads with the next NONSEQ held through the wait.
        add(32'h0, 3'd2, 1'b0, 32'h0);
        add(32'h4, 3'd2, 1'b0, 32'h0);
        add(32'h8, 3'd2, 1'b1, 32'h0BADF00D);
        add(32'h8, 3'd2, 1'b0, 32'h0);
        run(1);
        chk("t4_rdata", last_rd, 32'h0BADF00D);

        // Illegal transfers: out of range, misaligned, oversize, dropped write.
        for (int d = 0; d < 2; d++) begin
            add(32'h400, 3'd2, 1'b0, 32'h0);
            add(32'h1, 3'd1, 1'b0, 32'h0);
            add(32'h0, 3'd3, 1'b0, 32'h0);
            add(32'h2, 3'd2, 1'b1, 32'hFFFFFFFF);
            add(32'h0, 3'd2, 1'b0, 32'h0);
            run(d);
        end

        // Non-transfers must be ignored.
        for (int k = 0; k < 3; k++) begin
            hsel_v[0] = (k < 2); htrans_v[0] = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
            haddr_v[0] = 32'h20; hsize_v[0] = 3'd2; hwrite_v[0] = 1'b1; hwdata_v[0] = $urandom;
            @(negedge hclk);
            chk("t6_ready", hready_v[0], 1'b1);
            chk("t6_resp", hresp_v[0], 1'b0);
            @(posedge hclk); #1;
        end
        hsel_v[0] = 1'b0; htrans_v[0] = 2'b00; hwdata_v[0] = 32'h0;
        add(32'h20, 3'd2, 1'b0, 32'h0);
        run(0);

        // Reset in mid-wait abandons the pending write.
        hsel_v[2] = 1'b1; htrans_v[2] = 2'b10; haddr_v[2] = 32'h14; hsize_v[2] = 3'd2; hwrite_v[2] = 1'b1;
        @(posedge hclk); #1;
        hsel_v[2] = 1'b0; htrans_v[2] = 2'b00; hwdata_v[2] = 32'hCAFEF00D;
        chk("t1_in_wait", hready_v[2], 1'b0);
        @(posedge hclk); #1;
        hreset = 1'b1;
        #1;
        chk("t1_rst_ready", hready_v[2], 1'b1);
        chk("t1_rst_resp", hresp_v[2], 1'b0);
        chk("t1_rst_rdata", hrdata_v[2], 32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        hwdata_v[2] = 32'h0;
        @(posedge hclk); #1;
        add(32'h14, 3'd2, 1'b0, 32'h0);
        run(2);

        // Random traffic over words 0..15 plus occasional out-of-range addresses.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 80; n++)
                add(($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 15) : 32'($urandom_range(0, 63)),
                    3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            run(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
